// File: rtl/return_target_checker_if.sv
// rtl/return_target_checker_if.sv - prediction/resolve bus of the return target checker
// Stats ports exist only when RAS_CHECK_STATS_EN is defined.
interface return_target_checker_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic                     pred_valid_in;
  logic [XLEN-1:0]          pred_addr_in;
  logic                     pred_ready_out;
  logic                     resolve_valid_in;
  logic [XLEN-1:0]          actual_addr_in;
  logic                     flush_in;
  logic                     mispredict_out;
  logic [XLEN-1:0]          redirect_addr_out;
  logic [$clog2(DEPTH):0]   outstanding_out;
`ifdef RAS_CHECK_STATS_EN
  logic [31:0]              hit_count_out;
  logic [31:0]              miss_count_out;
`endif

  modport master (
    output pred_valid_in, pred_addr_in, resolve_valid_in, actual_addr_in, flush_in,
    input  pred_ready_out, mispredict_out, redirect_addr_out, outstanding_out
`ifdef RAS_CHECK_STATS_EN
    , input hit_count_out, miss_count_out
`endif
  );

  modport slave (
    input  pred_valid_in, pred_addr_in, resolve_valid_in, actual_addr_in, flush_in,
    output pred_ready_out, mispredict_out, redirect_addr_out, outstanding_out
`ifdef RAS_CHECK_STATS_EN
    , output hit_count_out, miss_count_out
`endif
  );
endinterface

// File: rtl/return_target_checker.sv
// rtl/return_target_checker.sv - queues predicted return addresses and flags wrong ones at jalr resolve
// Optional hit/miss statistics counters are enabled by defining RAS_CHECK_STATS_EN.
module return_target_checker #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  return_target_checker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, RECOVER} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]   count, count_next;
  logic            mispredict, mispredict_next;
  logic [XLEN-1:0] redirect_addr, redirect_next;
  logic            head_match, ready, push, hit, miss;

  assign head_match = (bus.actual_addr_in == mem[rd_ptr]);

  always_comb begin
    ready           = (state != RECOVER) &&
                      ((count < FULL) || (count == FULL && bus.resolve_valid_in && head_match));
    hit             = 1'b0;
    miss            = 1'b0;
    push            = 1'b0;
    state_next      = state;
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    count_next      = count;
    mispredict_next = 1'b0;
    redirect_next   = redirect_addr;

    if (bus.flush_in) begin
      rd_ptr_next = wr_ptr;
      count_next  = '0;
      state_next  = IDLE;
    end else if (state == RECOVER) begin
      state_next = IDLE;
    end else begin
      // A resolve with nothing queued counts as a miss: no prediction covered it.
      hit  = bus.resolve_valid_in && (count != '0) && head_match;
      miss = bus.resolve_valid_in && !hit;
      push = bus.pred_valid_in && ready && !miss;
      if (miss) begin
        rd_ptr_next     = wr_ptr;
        count_next      = '0;
        mispredict_next = 1'b1;
        redirect_next   = bus.actual_addr_in;
        state_next      = RECOVER;
      end else begin
        if (push) wr_ptr_next = wr_ptr + PW'(1);
        if (hit)  rd_ptr_next = rd_ptr + PW'(1);
        count_next = count + CW'(push) - CW'(hit);
        state_next = (count_next == '0) ? IDLE : TRACK;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      mispredict    <= 1'b0;
      redirect_addr <= '0;
    end else begin
      state         <= state_next;
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      count         <= count_next;
      mispredict    <= mispredict_next;
      redirect_addr <= redirect_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bus.pred_addr_in;
  end

  assign bus.pred_ready_out    = ready;
  assign bus.mispredict_out    = mispredict;
  assign bus.redirect_addr_out = redirect_addr;
  assign bus.outstanding_out   = count;

`ifdef RAS_CHECK_STATS_EN
  logic [31:0] hit_count, miss_count;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(hit);
      miss_count <= miss_count + 32'(miss);
    end
  end

  assign bus.hit_count_out  = hit_count;
  assign bus.miss_count_out = miss_count;
`endif
endmodule

// File: doc/return_target_checker.md
Name: return_target_checker

Overview:
- Back end of the return-prediction path.
- Queues each return address predicted at fetch in program order.
- When the matching jalr resolves in execute, compares the predicted address with the real target.
- On a mismatch, raises a one-cycle redirect/flush request to fetch and discards all younger queued predictions, since they are on the wrong path.

Parameters:
- XLEN, 64, address width.
- DEPTH, 4, number of outstanding return predictions held; must be a power of 2 and at least 2.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- pred_valid_in  input  1  fetch issued a return prediction this cycle.
- pred_addr_in  input  XLEN  predicted return address.
- pred_ready_out  output  1  queue can accept a prediction this cycle.
- resolve_valid_in  input  1  a predicted jalr resolved in execute this cycle.
- actual_addr_in  input  XLEN  resolved jalr target.
- flush_in  input  1  external pipeline flush; kills all outstanding predictions.
- mispredict_out  output  1  one-cycle pulse, registered: the oldest prediction was wrong.
- redirect_addr_out  output  XLEN  correct target, valid while mispredict_out=1.
- outstanding_out  output  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - The count is separate and saturates at neither end (it is guarded instead).
- Reset (rst_n_in=0 at a rising edge):
  - Pointers=0, count=0, state=IDLE.
  - mispredict_out=0, redirect_addr_out=0, pred_ready_out=1, outstanding_out=0.
  - Reset has priority over every other input, including mid-recovery.
- FSM states:
  - IDLE: count=0.
  - TRACK: count>0.
  - RECOVER: one cycle after a mismatch.
- pred_ready_out:
  - Combinational: 1 when state!=RECOVER and (count<DEPTH, or count==DEPTH with a matching resolve this cycle).
- Push:
  - Occurs when pred_valid_in & pred_ready_out & ~flush_in.
  - pred_addr_in is written at the write pointer, and the write pointer increments.
  - pred_valid_in while not ready is dropped silently.
- Resolve, in IDLE/TRACK with flush_in=0:
  - Count>0 and actual_addr_in == head entry: pop the head (read pointer +1), no pulse.
  - Count>0 and mismatch:
    - Next cycle mispredict_out=1 and redirect_addr_out=actual_addr_in.
    - FIFO is cleared (read pointer=write pointer, count=0); any same-cycle push is discarded.
    - Go to RECOVER.
  - Count==0: treated as a mismatch (no prediction existed); pulse and redirect to actual_addr_in, then go to RECOVER.
- Simultaneous push and matching pop: count unchanged, both pointers advance.
- flush_in=1:
  - Clears the FIFO at the next edge and goes to IDLE.
  - Overrides push and resolve in the same cycle; no mispredict pulse is generated.
- RECOVER:
  - Lasts exactly one cycle; pred_ready_out=0.
  - Resolves are ignored.
  - Then go to IDLE.
- mispredict_out:
  - Is never high for two consecutive cycles.
  - Latency is 1 cycle from resolve to pulse.
  - redirect_addr_out holds its last value when mispredict_out=0.
- Address comparison: full XLEN equality; no masking of bit 0.

Optional Feature:
- Macro: RAS_CHECK_STATS_EN.
- When defined:
  - Adds outputs hit_count_out [31:0] and miss_count_out [31:0], both reset to 0.
  - hit_count_out increments on each matching resolve.
  - miss_count_out increments on each mismatch, including a resolve on an empty queue.
  - Both wrap at 2^32; neither changes on flush.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then push 0x1000 and 0x2000; resolve 0x1000, then 0x2000 -> mispredict_out stays 0; outstanding_out goes 0,1,2,1,0.
- Push 0x1000, 0x2000, 0x3000; resolve 0x1004 -> next cycle mispredict_out=1 with redirect_addr_out=0x1004; outstanding_out=0; pred_ready_out=0 for one cycle, then 1.
- Fill all 4 entries -> pred_ready_out=0 and a 5th push is dropped; then a matching resolve plus a push in the same cycle -> outstanding_out stays 4 and the new entry becomes the tail.
- Resolve 0x5000 with the queue empty -> one-cycle pulse, redirect_addr_out=0x5000, state returns to IDLE.
- Push 2 entries, then assert flush_in together with a mismatching resolve -> no pulse; outstanding_out=0 next cycle.
- With RAS_CHECK_STATS_EN: 3 hits and 2 misses -> hit_count_out=3, miss_count_out=2; rst_n_in low for one edge mid-sequence -> both counters 0 and the FIFO empty.
